// File: rtl/depth_sort_pkg.sv
// rtl/depth_sort_pkg.sv - vertex and triangle record types shared by the depth sorter and its users
//
// vertex_2d_t : projected vertex; only the signed 10-bit depth is consumed by the sorter
// triangle_t  : three vertex indices plus a 12-bit color
package depth_sort_pkg;

  typedef struct packed {
    logic signed [9:0] z;
  } vertex_2d_t;

  typedef struct packed {
    logic [4:0]  v0;
    logic [4:0]  v1;
    logic [4:0]  v2;
    logic [11:0] color;
  } triangle_t;

endpackage

// File: rtl/depth_sort_engine.sv
// rtl/depth_sort_engine.sv - per-frame back-to-front triangle sorter feeding the rasterizer
//
// Snapshots the vertex depths and triangle list on start, builds a depth key per
// triangle (one per cycle), orders the list with an odd-even transposition network
// (one phase per cycle) and publishes the result atomically in COMMIT.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle frame pulse, ignored while busy
//   vertices_2d       projected vertices (depth only)
//   triangles_in      unsorted triangle list
//   num_triangles     valid triangle count (clamped to N_TRI)
//   triangles_sorted  published list, farthest first
//   sorted_indices    original slot of each published entry
//   num_sorted        valid entries in the published list
//   busy              high from the cycle after start through COMMIT
//   done              one-cycle pulse, first cycle the new list is visible
//
// Build option DEPTH_SORT_BYPASS_EN: the sort stage is left out and the list is
// published in clamped input order straight after LOAD.
module depth_sort_engine
  import depth_sort_pkg::*;
#(
  parameter int N_TRI  = 24,
  parameter int N_VERT = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  vertex_2d_t vertices_2d      [0:N_VERT-1],
  input  triangle_t  triangles_in     [0:N_TRI-1],
  input  logic [4:0] num_triangles,
  output triangle_t  triangles_sorted [0:N_TRI-1],
  output logic [4:0] sorted_indices   [0:N_TRI-1],
  output logic [4:0] num_sorted,
  output logic       busy,
  output logic       done
);

  localparam logic [4:0] LAST    = 5'(N_TRI - 1);
  localparam logic [4:0] TRI_MAX = 5'(N_TRI);

`ifdef DEPTH_SORT_BYPASS_EN
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, SORT, COMMIT} state_t;
`endif

  state_t state_q, state_d;

  triangle_t  tri_snap [0:N_TRI-1];
  logic [4:0] count_snap;
  logic [4:0] cnt;
  triangle_t  w_tri    [0:N_TRI-1];
  logic [4:0] w_idx    [0:N_TRI-1];

`ifndef DEPTH_SORT_BYPASS_EN
  logic signed [9:0]  z_snap [0:N_VERT-1];
  logic signed [11:0] w_key  [0:N_TRI-1];
  logic signed [11:0] load_key;

  // Out-of-range vertex indices contribute zero depth.
  function automatic logic signed [11:0] vert_z(input logic [4:0] vi);
    if (int'(vi) < N_VERT) return {{2{z_snap[vi][9]}}, z_snap[vi]};
    else                   return 12'sd0;
  endfunction

  // Padding slots get the most-negative key so they sink to the tail.
  always_comb begin
    triangle_t cur;
    cur      = tri_snap[cnt];
    load_key = 12'sh800;
    if (cnt < count_snap)
      load_key = vert_z(cur.v0) + vert_z(cur.v1) + vert_z(cur.v2);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        busy = 1'b1;
`ifdef DEPTH_SORT_BYPASS_EN
        if (cnt == LAST) state_d = COMMIT;
`else
        if (cnt == LAST) state_d = SORT;
`endif
      end
`ifndef DEPTH_SORT_BYPASS_EN
      SORT: begin
        busy = 1'b1;
        if (cnt == LAST) state_d = COMMIT;
      end
`endif
      COMMIT: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      count_snap <= '0;
      num_sorted <= '0;
      done       <= 1'b0;
      for (int i = 0; i < N_TRI; i++) begin
        triangles_sorted[i] <= '0;
        sorted_indices[i]   <= 5'(i);
      end
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          tri_snap   <= triangles_in;
          count_snap <= (num_triangles > TRI_MAX) ? TRI_MAX : num_triangles;
          cnt        <= '0;
`ifndef DEPTH_SORT_BYPASS_EN
          for (int i = 0; i < N_VERT; i++) z_snap[i] <= vertices_2d[i].z;
`endif
        end
        LOAD: begin
          w_tri[cnt] <= tri_snap[cnt];
          w_idx[cnt] <= cnt;
`ifndef DEPTH_SORT_BYPASS_EN
          w_key[cnt] <= load_key;
`endif
          cnt <= (cnt == LAST) ? '0 : cnt + 5'd1;
        end
`ifndef DEPTH_SORT_BYPASS_EN
        // Even phases pair (0,1),(2,3)..; odd phases pair (1,2),(3,4)..
        // Strict compare keeps equal keys in original order.
        SORT: begin
          for (int i = 0; i < N_TRI - 1; i++) begin
            if ((i[0] == cnt[0]) && (w_key[i] < w_key[i+1])) begin
              w_key[i]   <= w_key[i+1];
              w_key[i+1] <= w_key[i];
              w_tri[i]   <= w_tri[i+1];
              w_tri[i+1] <= w_tri[i];
              w_idx[i]   <= w_idx[i+1];
              w_idx[i+1] <= w_idx[i];
            end
          end
          cnt <= (cnt == LAST) ? '0 : cnt + 5'd1;
        end
`endif
        COMMIT: begin
          for (int i = 0; i < N_TRI; i++) begin
            triangles_sorted[i] <= w_tri[i];
            sorted_indices[i]   <= w_idx[i];
          end
          num_sorted <= count_snap;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_depth_sort_engine.sv
// tb/tb_depth_sort_engine.sv - directed self-checking bench for depth_sort_engine
module tb_depth_sort_engine;
  import depth_sort_pkg::*;

  localparam int N_TRI  = 24;
  localparam int N_VERT = 18;
`ifdef DEPTH_SORT_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int LAT = 26;
`else
  localparam bit BYP = 1'b0;
  localparam int LAT = 50;
`endif
  localparam int RST_AT = LAT - 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  vertex_2d_t vertices_2d      [0:N_VERT-1];
  triangle_t  triangles_in     [0:N_TRI-1];
  logic [4:0] num_triangles;
  triangle_t  triangles_sorted [0:N_TRI-1];
  logic [4:0] sorted_indices   [0:N_TRI-1];
  logic [4:0] num_sorted;
  logic       busy;
  logic       done;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int exp_idx [N_TRI];

  depth_sort_engine #(.N_TRI(N_TRI), .N_VERT(N_VERT)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .vertices_2d      (vertices_2d),
    .triangles_in     (triangles_in),
    .num_triangles    (num_triangles),
    .triangles_sorted (triangles_sorted),
    .sorted_indices   (sorted_indices),
    .num_sorted       (num_sorted),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_scene();
    for (int i = 0; i < N_VERT; i++) vertices_2d[i].z = 10'sd0;
    for (int t = 0; t < N_TRI; t++) begin
      triangles_in[t].v0    = 5'd0;
      triangles_in[t].v1    = 5'd0;
      triangles_in[t].v2    = 5'd0;
      triangles_in[t].color = 12'(100 + t);
    end
  endtask

  task automatic set_tri(input int t, input int a, input int b, input int c);
    triangles_in[t].v0 = 5'(a);
    triangles_in[t].v1 = 5'(b);
    triangles_in[t].v2 = 5'(c);
  endtask

  // Key k in 0..23 with vertex z[i] = i; index 31 adds zero depth.
  task automatic set_key(input int t, input int k);
    if (k <= 17) set_tri(t, k, 31, 31);
    else         set_tri(t, 17, k - 17, 31);
  endtask

  task automatic setup_three();
    clear_scene();
    vertices_2d[0].z = 10'sd10;
    vertices_2d[1].z = 10'sd100;
    vertices_2d[2].z = -10'sd30;
    set_tri(0, 0, 0, 0);
    set_tri(1, 1, 1, 1);
    set_tri(2, 2, 2, 2);
    num_triangles = 5'd3;
    exp_idx[0] = 1;
    exp_idx[1] = 0;
    exp_idx[2] = 2;
    for (int i = 3; i < N_TRI; i++) exp_idx[i] = i;
  endtask

  task automatic exp_identity();
    for (int i = 0; i < N_TRI; i++) exp_idx[i] = i;
  endtask

  task automatic check_order(input string tag);
    int e;
    for (int i = 0; i < N_TRI; i++) begin
      e = BYP ? i : exp_idx[i];
      chk($sformatf("%s_idx%0d", tag, i), 32'(sorted_indices[i]), e);
      chk($sformatf("%s_col%0d", tag, i), 32'(triangles_sorted[i].color), 100 + e);
    end
  endtask

  // One frame: start pulse, then watch done/busy for a bounded window.
  task automatic frame(input string tag, input bit scramble);
    int  done_at;
    int  ndone;
    bit  busy_ok;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (scramble) begin
      for (int i = 0; i < N_VERT; i++) vertices_2d[i].z = 10'sd0;
      for (int t = 0; t < N_TRI; t++) set_tri(t, 0, 0, 0);
      num_triangles = 5'd0;
    end
    done_at = -1;
    ndone   = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= LAT + 5; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (busy !== (c < LAT)) busy_ok = 1'b0;
      tick();
    end
    chk({tag, "_done_at"}, done_at, LAT);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_busy_window"}, 32'(busy_ok), 1);
  endtask

  initial begin
    int ndone;
    int d1;
    int d2;

    rst           = 1'b1;
    start         = 1'b0;
    num_triangles = 5'd0;
    clear_scene();
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rst_num_sorted", 32'(num_sorted), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tri0", 32'(triangles_sorted[0]), 0);
    chk("rst_tri23", 32'(triangles_sorted[23]), 0);
    for (int i = 0; i < N_TRI; i++) chk($sformatf("rst_idx%0d", i), 32'(sorted_indices[i]), i);

    setup_three();
    frame("three", 1'b1);
    chk("three_num", 32'(num_sorted), 3);
    check_order("three");

    clear_scene();
    num_triangles = 5'd24;
    frame("flat", 1'b0);
    exp_identity();
    check_order("flat");

    clear_scene();
    for (int i = 0; i < N_VERT; i++) vertices_2d[i].z = 10'(i);
    for (int t = 0; t < N_TRI; t++) set_key(t, 23 - t);
    frame("desc", 1'b0);
    exp_identity();
    check_order("desc");

    for (int t = 0; t < N_TRI; t++) set_key(t, t);
    frame("asc", 1'b0);
    for (int i = 0; i < N_TRI; i++) exp_idx[i] = 23 - i;
    check_order("asc");

    clear_scene();
    num_triangles = 5'd31;
    frame("clamp", 1'b0);
    chk("clamp_num", 32'(num_sorted), 24);
    exp_identity();
    check_order("clamp");

    clear_scene();
    vertices_2d[5].z = 10'sd500;
    set_tri(7, 5, 5, 5);
    num_triangles = 5'd5;
    frame("pad", 1'b0);
    chk("pad_num", 32'(num_sorted), 5);
    exp_identity();
    check_order("pad");

    setup_three();
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    d1    = -1;
    d2    = -1;
    for (int c = 1; c <= 2 * LAT + 5; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      start = (c == 10) || (c == LAT - 1) || (c == LAT);
      tick();
    end
    start = 1'b0;
    chk("coll_ndone", ndone, 2);
    chk("coll_first", d1, LAT);
    chk("coll_second", d2, 2 * LAT);
    check_order("coll");

    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("rststart_num", 32'(num_sorted), 0);
    ndone = 0;
    for (int c = 1; c <= LAT + 5; c++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      tick();
    end
    chk("rststart_idle", ndone, 0);

    setup_three();
    frame("pre", 1'b0);
    chk("pre_num", 32'(num_sorted), 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c < RST_AT; c++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_no_done_before", ndone, 0);
    chk("mid_num", 32'(num_sorted), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_tri0", 32'(triangles_sorted[0]), 0);
    chk("mid_idx0", 32'(sorted_indices[0]), 0);
    chk("mid_idx1", 32'(sorted_indices[1]), 1);
    ndone = 0;
    for (int c = 1; c <= LAT + 5; c++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    chk("mid_no_done_after", ndone, 0);
    frame("after", 1'b0);
    chk("after_num", 32'(num_sorted), 3);
    check_order("after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/depth_sort_engine.md
# depth_sort_engine

Multi-cycle painter's-algorithm sorter that sits directly upstream of the rasterizer. Once per frame it snapshots the projected vertex list and triangle list, computes a depth key per triangle, and reorders the triangles back-to-front with an odd-even transposition network. It then atomically publishes the sorted list, which the rasterizer consumes unchanged for the whole frame.

## Interface
Parameters:
- N_TRI, 24, triangle slots; equals the rasterizer's list depth.
- N_VERT, 18, vertex slots.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle frame pulse; begins a sort.
- vertices_2d  in  vertex_2d_t[0:N_VERT-1]  projected vertices.
  - Only `.z` is used. It is signed 10-bit.
- triangles_in  in  triangle_t[0:N_TRI-1]  unsorted triangles (v0/v1/v2 indices, color).
- num_triangles  in  5  valid triangle count.
- triangles_sorted  out  triangle_t[0:N_TRI-1]  published list, farthest first.
- sorted_indices  out  5 x N_TRI  original slot index of each published entry.
- num_sorted  out  5  valid entries in the published list.
- busy  out  1  high from the cycle after `start` is accepted through COMMIT.
- done  out  1  one-cycle pulse; first cycle the new list is visible.

## Operation
- **States:** IDLE, LOAD, SORT, COMMIT.
- **IDLE:**
  - On `start`, snapshot the following into shadow registers: `triangles_in`, all `vertices_2d[i].z`, and `num_triangles`.
  - Clamp the snapshot count to N_TRI when `num_triangles > N_TRI`.
  - Go to LOAD with `t = 0`.
- **LOAD:**
  - Process one triangle per cycle, `t = 0..N_TRI-1`. Each cycle writes the working entry `{tri, idx=t, key}`.
  - `key = z[v0] + z[v1] + z[v2]`, sign-extended to 12 bits. No overflow occurs: the range is -1536..1533.
  - Slots with `t >= count` get `key = -2048`.
  - Go to SORT after `t = N_TRI-1`.
- **SORT:**
  - N_TRI phases, one per cycle, with phase counter `p`.
  - Even `p` compares pairs (0,1),(2,3),…; odd `p` compares pairs (1,2),(3,4),….
  - Swap a pair only if `key[left] < key[right]` (strict). This keeps equal keys in original index order, so the sort is stable.
  - Result: keys in descending order (larger z = farther = drawn first); padding slots land at the tail.
- **COMMIT:**
  - Copy the working tri/idx arrays to `triangles_sorted` / `sorted_indices`, and the count to `num_sorted`.
  - Go to IDLE.
- Outputs change only at COMMIT. The rasterizer never sees a partially sorted list.
- `start` while busy is ignored. It is not queued.
- Upstream may change inputs freely after the `start` cycle.
- Vertex indices ≥ N_VERT in a valid triangle contribute z = 0 to that triangle's key.

## Timing
- `start` sampled high in cycle k (IDLE):
  - LOAD occupies cycles k+1..k+24.
  - SORT occupies cycles k+25..k+48.
  - COMMIT occurs at cycle k+49.
  - `done` = 1 and the new outputs are visible at k+50.
  - `busy` = 1 for cycles k+1..k+49.
- A new `start` is accepted in cycle k+50 at the earliest. This allows back-to-back frames at a 50-cycle period, far below a frame time.
- **Reset values:**
  - `triangles_sorted`: all zero.
  - `sorted_indices[i] = i`.
  - `num_sorted`: 0, so nothing is drawn.
  - `busy`, `done`: 0.
  - State: IDLE; counters: 0.
- `rst` mid-operation aborts the sort. All outputs return to reset values the next cycle. No partial commit occurs.
- `rst` and `start` in the same cycle: `rst` wins and `start` is dropped.

## Configuration
- **`DEPTH_SORT_BYPASS_EN` defined:**
  - SORT state is not built; LOAD goes straight to COMMIT.
  - Output is the clamped input order, with `sorted_indices[i] = i`.
  - `done` arrives at k+26; `busy` covers k+1..k+25.
- **`DEPTH_SORT_BYPASS_EN` undefined:** full sort as above.

## Test plan
- **Reset check:** reset, then idle 10 cycles -> `num_sorted` = 0, `sorted_indices` = 0..23, `busy` = 0, `done` = 0.
- **Three-triangle sort:**
  - Stimulus: 3 triangles with keys 30, 300, -90 (slots 0,1,2); `start` at k.
  - Response: `done` exactly at k+50; `sorted_indices[0..2]` = 1,0,2; `num_sorted` = 3; busy high k+1..k+49.
- **Stability:**
  - Stimulus: 24 triangles all with key 0.
  - Response: order unchanged (0..23). Then reverse-ordered keys 23..0 → indices 0..23; ascending keys 0..23 → indices 23..0.
- **Count clamp / padding:**
  - `num_triangles` = 31 → `num_sorted` = 24.
  - `num_triangles` = 5 with slot 7 holding key +1500 → slot 7 is absent from entries 0..4 and sits in the tail.
- **Start collision:** `start` again at k+10 and k+49 -> ignored, a single `done` at k+50. `start` at k+50 → next `done` at k+100.
- **Mid-sort reset:** `rst` at k+30 -> outputs return to reset values at k+31, no `done` pulse, and the next `start` behaves normally. Rerun all tests with `DEPTH_SORT_BYPASS_EN`, expecting `done` at k+26 and identity order.
